// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V definitions: funct3 access encodings, MEM-stage FSM states
// and small helpers for decoding access size and alignment.
package riscv_defs_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    // Encodings outside byte/half fall back to word size.
    function automatic acc_size_e f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] f3_lo, input logic [1:0] off);
        case (f3_size(f3_lo))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational lane steering: store data replication plus byte enables,
// and load byte/half extraction with sign or zero extension.
module mem_align
    import riscv_defs_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    acc_size_e                        st_size;
    acc_size_e                        ld_size;
    logic [NUM_LANES-1:0][7:0]        wlane;
    logic [31:0]                      ld_shift;

    assign st_size = f3_size(st_funct3[1:0]);
    assign ld_size = f3_size(ld_funct3[1:0]);

    // Each lane picks the store byte it carries for the current access size.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_comb begin
            case (st_size)
                SZ_B:    wlane[i] = st_data[7:0];
                SZ_H:    wlane[i] = st_data[8*(i%2) +: 8];
                default: wlane[i] = st_data[8*i +: 8];
            endcase
        end
    end

    assign st_wdata = wlane;

    // Byte enables shifted to the addressed lane.
    always_comb begin
        case (st_size)
            SZ_B:    st_be = 4'b0001 << st_off;
            SZ_H:    st_be = 4'b0011 << st_off;
            default: st_be = 4'hF;
        endcase
    end

    assign ld_shift = ld_rdata >> {ld_off, 3'b000};

    // Extract the addressed byte/half; funct3[2] selects zero extension.
    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = ld_funct3[2] ? {24'h0, ld_shift[7:0]}
                                            : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = ld_funct3[2] ? {16'h0, ld_shift[15:0]}
                                            : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: converts the EX/MEM access into a handshaked bus transaction,
// stalls the front of the pipeline while it is outstanding and aborts with
// a bus error when no ack arrives within TIMEOUT_CYCLES.
module mem_access_stage
    import riscv_defs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [2:0]        MEM_funct3,
    input  logic [31:0]       MEM_ALUResult,
    input  logic [31:0]       MEM_rs2_data,
    input  logic              MEM_RegWrite,
    output logic              MEM_RegWrite_o,
    output logic [31:0]       MEM_MemData,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    localparam int          CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        data_q;
    logic               buserr_q;
    logic [2:0]         ld_f3_q;
    logic [1:0]         ld_off_q;
    logic               ld_is_q;

    logic               acc;
    logic               misal;
    logic               timeout;
    logic [31:0]        st_wdata;
    logic [3:0]         st_be;
    logic [31:0]        ld_data;

    assign acc     = MEM_MemRead | MEM_MemWrite;
    assign misal   = is_misaligned(MEM_funct3[1:0], MEM_ALUResult[1:0]);
    assign timeout = (cnt == CNT_LAST);

    mem_align u_align (
        .st_funct3 (MEM_funct3),
        .st_off    (MEM_ALUResult[1:0]),
        .st_data   (MEM_rs2_data),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_funct3 (ld_f3_q),
        .ld_off    (ld_off_q),
        .ld_rdata  (dmem_rdata),
        .ld_data   (ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state plus stall/gating outputs towards the pipeline.
    always_comb begin
        state_nxt      = state;
        mem_stall      = 1'b0;
        mem_fault      = 1'b0;
        MEM_RegWrite_o = MEM_RegWrite;
        MEM_MemData    = 32'h0;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    MEM_RegWrite_o = 1'b0;
                    if (misal) begin
                        mem_fault = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                mem_stall      = 1'b1;
                MEM_RegWrite_o = 1'b0;
                if (dmem_ack || timeout) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                MEM_MemData    = data_q;
                MEM_RegWrite_o = MEM_RegWrite & ~buserr_q;
                mem_fault      = buserr_q;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus request registers, timeout counter and load result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'h0;
            dmem_be    <= 4'h0;
            cnt        <= '0;
            data_q     <= 32'h0;
            buserr_q   <= 1'b0;
            ld_f3_q    <= 3'b000;
            ld_off_q   <= 2'b00;
            ld_is_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc && !misal) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MemWrite;
                        dmem_addr  <= {MEM_ALUResult[ADDR_W-1:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= st_be;
                        cnt        <= '0;
                        data_q     <= 32'h0;
                        buserr_q   <= 1'b0;
                        ld_f3_q    <= MEM_funct3;
                        ld_off_q   <= MEM_ALUResult[1:0];
                        ld_is_q    <= ~MEM_MemWrite;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        data_q   <= ld_is_q ? ld_data : 32'h0;
                    end else if (timeout) begin
                        dmem_req <= 1'b0;
                        data_q   <= 32'h0;
                        buserr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table, randomized transactions
// against an arithmetic reference model, and a mid-transaction reset.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, rw = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [31:0] addr = 32'h0, rs2 = 32'h0;
    logic        rw_o, stall, fault;
    logic [31:0] mdata;
    logic        req, we;
    logic [31:0] daddr, wdata, rdata = 32'h0;
    logic [3:0]  be;
    logic        ack = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .MEM_MemRead    (rd),
        .MEM_MemWrite   (wr),
        .MEM_funct3     (f3),
        .MEM_ALUResult  (addr),
        .MEM_rs2_data   (rs2),
        .MEM_RegWrite   (rw),
        .MEM_RegWrite_o (rw_o),
        .MEM_MemData    (mdata),
        .mem_stall      (stall),
        .mem_fault      (fault),
        .dmem_req       (req),
        .dmem_we        (we),
        .dmem_addr      (daddr),
        .dmem_wdata     (wdata),
        .dmem_be        (be),
        .dmem_ack       (ack),
        .dmem_rdata     (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, rw;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        int          lat;      // BUSY cycles before ack; >=T means never
        logic        e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic        e_rw;
        logic        e_fault;
        int          e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        rd = 1'b0; wr = 1'b0; rw = 1'b0;
        f3 = 3'b0; addr = 32'h0; rs2 = 32'h0;
    endtask

    // Reference model: expected behaviour from the access rules alone.
    function automatic int unsigned m_size(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic vec_t model(input logic r, input logic w, input logic rwi,
                                   input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] s, input logic [31:0] d, input int lat);
        vec_t v;
        int unsigned sz, off;
        logic [31:0] sh, ld;
        logic        berr;
        sz  = m_size(f);
        off = a % 4;
        v.rd = r; v.wr = w; v.rw = rwi; v.f3 = f; v.addr = a; v.rs2 = s; v.rdata = d; v.lat = lat;
        v.e_mis   = ((a % sz) != 0);
        v.e_be    = (sz == 4) ? 4'hF : 4'(((sz == 1) ? 1 : 3) << off);
        v.e_wdata = (sz == 1) ? (s & 32'hFF) * 32'h01010101 :
                    (sz == 2) ? (s & 32'hFFFF) * 32'h00010001 : s;
        sh = d >> (8 * off);
        if (sz == 1) begin
            ld = sh & 32'hFF;
            if (!f[2] && ld >= 32'd128) ld = ld | 32'hFFFFFF00;
        end else if (sz == 2) begin
            ld = sh & 32'hFFFF;
            if (!f[2] && ld >= 32'h8000) ld = ld | 32'hFFFF0000;
        end else begin
            ld = d;
        end
        berr      = (lat >= T);
        v.e_data  = (berr || w) ? 32'h0 : ld;
        v.e_rw    = rwi & ~berr;
        v.e_fault = berr;
        v.e_stall = v.e_mis ? 0 : ((berr ? T : lat + 1) + 1);
        if (v.e_mis) begin
            v.e_rw = 1'b0; v.e_fault = 1'b1; v.e_data = 32'h0;
        end
        return v;
    endfunction

    // Drive one access through IDLE/BUSY/DONE, checking every cycle.
    task automatic run_txn(input vec_t v, input string tag);
        int stalls;
        rd = v.rd; wr = v.wr; rw = v.rw; f3 = v.f3; addr = v.addr; rs2 = v.rs2;
        #1;
        if (v.e_mis) begin
            chk({tag, " mis_fault"}, 32'(fault), 32'(v.e_fault));
            chk({tag, " mis_stall"}, 32'(stall), 32'h0);
            chk({tag, " mis_rw"}, 32'(rw_o), 32'h0);
            step();
            chk({tag, " mis_noreq"}, 32'(req), 32'h0);
            nop();
            #1;
            chk({tag, " mis_fault_gone"}, 32'(fault), 32'h0);
            return;
        end
        chk({tag, " idle_stall"}, 32'(stall), 32'h1);
        chk({tag, " idle_rw"}, 32'(rw_o), 32'h0);
        stalls = 1;
        step();
        chk({tag, " req"}, 32'(req), 32'h1);
        chk({tag, " we"}, 32'(we), 32'(v.wr));
        chk({tag, " be"}, 32'(be), 32'(v.e_be));
        chk({tag, " wdata"}, wdata, v.e_wdata);
        for (int k = 0; k < T; k++) begin
            chk({tag, " busy_stall"}, 32'(stall), 32'h1);
            chk({tag, " busy_rw"}, 32'(rw_o), 32'h0);
            chk({tag, " busy_addr"}, daddr, {v.addr[31:2], 2'b00});
            stalls++;
            addr[1:0] = 2'($urandom);   // load offset must come from the latched copy
            if (k == v.lat) begin
                ack = 1'b1; rdata = v.rdata;
            end
            step();
            ack = 1'b0; rdata = $urandom;
            if (k == v.lat) break;
        end
        chk({tag, " done_stall"}, 32'(stall), 32'h0);
        chk({tag, " done_req"}, 32'(req), 32'h0);
        chk({tag, " done_data"}, mdata, v.e_data);
        chk({tag, " done_rw"}, 32'(rw_o), 32'(v.e_rw));
        chk({tag, " done_fault"}, 32'(fault), 32'(v.e_fault));
        chk({tag, " stall_cycles"}, 32'(stalls - 1), 32'(v.e_stall - 1));
        step();
        nop();
        #1;
        chk({tag, " back_idle"}, 32'(stall | fault | req), 32'h0);
    endtask

    vec_t tbl[12];

    initial begin
        // Directed vectors with hand-derived expectations.
        //            rd wr rw f3      addr          rs2           rdata         lat mis be    wdata         data          rw fault stall
        tbl[0]  = '{1, 0, 1, 3'b010, 32'h100,      32'h0,        32'hDEADBEEF, 0,  0, 4'hF, 32'h0,        32'hDEADBEEF, 1, 0, 2};
        tbl[1]  = '{0, 1, 0, 3'b000, 32'h203,      32'hA5,       32'h0,        0,  0, 4'h8, 32'hA5A5A5A5, 32'h0,        0, 0, 2};
        tbl[2]  = '{1, 0, 1, 3'b000, 32'h2,        32'h0,        32'h00800000, 0,  0, 4'h4, 32'h0,        32'hFFFFFF80, 1, 0, 2};
        tbl[3]  = '{1, 0, 1, 3'b100, 32'h2,        32'h0,        32'h00800000, 1,  0, 4'h4, 32'h0,        32'h00000080, 1, 0, 3};
        tbl[4]  = '{1, 0, 1, 3'b001, 32'h2,        32'h0,        32'h80010000, 0,  0, 4'hC, 32'h0,        32'hFFFF8001, 1, 0, 2};
        tbl[5]  = '{1, 0, 1, 3'b001, 32'h101,      32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'h0,        0, 1, 0};
        tbl[6]  = '{1, 0, 1, 3'b010, 32'h300,      32'h0,        32'h12345678, 99, 0, 4'hF, 32'h0,        32'h0,        0, 1, 5};
        tbl[7]  = '{1, 0, 1, 3'b010, 32'h304,      32'h0,        32'hCAFEF00D, 3,  0, 4'hF, 32'h0,        32'hCAFEF00D, 1, 0, 5};
        tbl[8]  = '{0, 1, 0, 3'b001, 32'h102,      32'h1234ABCD, 32'h0,        0,  0, 4'hC, 32'hABCDABCD, 32'h0,        0, 0, 2};
        tbl[9]  = '{1, 0, 1, 3'b101, 32'h0,        32'h0,        32'h1234F00D, 2,  0, 4'h3, 32'h0,        32'h0000F00D, 1, 0, 4};
        tbl[10] = '{1, 1, 0, 3'b010, 32'h2,        32'h0,        32'h0,        0,  1, 4'h0, 32'h0,        32'h0,        0, 1, 0};
        tbl[11] = '{1, 0, 1, 3'b011, 32'h104,      32'h0,        32'h000055AA, 0,  0, 4'hF, 32'h0,        32'h000055AA, 1, 0, 2};

        // Reset state.
        #1;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_be", 32'(be), 32'h0);
        chk("rst_addr", daddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_data", mdata, 32'h0);
        #12 rstn = 1'b1;
        step();

        // Non-memory instruction passes RegWrite straight through.
        rw = 1'b1; #1;
        chk("nop_rw", 32'(rw_o), 32'h1);
        chk("nop_stall", 32'(stall), 32'h0);
        chk("nop_data", mdata, 32'h0);
        nop();
        step();

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic r, w, rwi;
            logic [2:0] f;
            vec_t v;
            w   = 1'($urandom);
            r   = w ? 1'($urandom) : 1'b1;
            rwi = ~w;
            f   = 3'($urandom);
            if (w) f[2] = 1'b0;
            v = model(r, w, rwi, f, $urandom, $urandom, $urandom, int'($urandom_range(0, T + 1)));
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Reset during BUSY: request drops at once, stray ack is ignored.
        rd = 1'b1; rw = 1'b1; f3 = 3'b010; addr = 32'h400;
        #1;
        chk("mr_idle_stall", 32'(stall), 32'h1);
        step();
        chk("mr_busy_req", 32'(req), 32'h1);
        rstn = 1'b0;
        #1;
        chk("mr_req_drop", 32'(req), 32'h0);
        chk("mr_stall_acc", 32'(stall), 32'h1);
        rd = 1'b0;
        #1;
        chk("mr_stall_noacc", 32'(stall), 32'h0);
        step();
        rstn = 1'b1;
        ack = 1'b1; rdata = 32'hFFFFFFFF;
        #1;
        chk("mr_ack_stall", 32'(stall), 32'h0);
        chk("mr_ack_rw", 32'(rw_o), 32'h1);
        step();
        ack = 1'b0;
        #1;
        chk("mr_after_req", 32'(req), 32'h0);
        chk("mr_after_stall", 32'(stall), 32'h0);
        chk("mr_after_fault", 32'(fault), 32'h0);
        chk("mr_after_data", mdata, 32'h0);
        nop();
        step();
        run_txn(tbl[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
